// File: rtl/segasys1_sprrom_fetch.sv
// Sprite chip-ROM responder: serves byte reads from a two-word cache, filling it from
// the 16-bit ROM port on demand misses and prefetching the neighbouring word in the walk direction.
module segasys1_sprrom_fetch #(
  parameter int LATE_CYC = 16
) (
  input  logic        VCLKx8,
  input  logic        RESETn,
  input  logic        dl_busy,
  input  logic [17:0] sprchad,
  output logic [7:0]  sprchdt,
  output logic        rom_req,
  output logic [16:0] rom_addr,
  input  logic        rom_valid,
  input  logic [15:0] rom_data,
  output logic        late
);
  localparam int CW = $clog2(LATE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEMAND, S_PREFETCH, S_DL} state_e;

  state_e            state_q;
  logic [1:0]        vld_q;
  logic [1:0][16:0]  tag_q;
  logic [1:0][15:0]  dat_q;
  logic [16:0]       prev_q, addr_q;
  logic              dir_dn_q, req_q, late_q;
  logic [7:0]        dt_q;
  logic [CW-1:0]     lcnt_q, lcnt_d;

  logic [16:0] word, nxt;
  logic        hit0, hit1, hit, nxt_hit, fill_sel;
  logic [15:0] hword;

  always_comb begin
    word     = sprchad[17:1];
    nxt      = dir_dn_q ? word - 17'd1 : word + 17'd1;
    hit0     = vld_q[0] && (tag_q[0] == word);
    hit1     = vld_q[1] && (tag_q[1] == word);
    hit      = hit0 || hit1;
    hword    = hit0 ? dat_q[0] : dat_q[1];
    nxt_hit  = (vld_q[0] && (tag_q[0] == nxt)) || (vld_q[1] && (tag_q[1] == nxt));
    // never evict the word the engine is currently reading
    fill_sel = hit0;
    lcnt_d   = lcnt_q;
    if (!hit) begin
      if (word != prev_q)                 lcnt_d = CW'(1);
      else if (lcnt_q != CW'(LATE_CYC))   lcnt_d = lcnt_q + CW'(1);
    end
  end

  always_ff @(posedge VCLKx8) begin
    if (!RESETn) begin
      state_q  <= S_IDLE;
      vld_q    <= '0;
      tag_q    <= '0;
      dat_q    <= '0;
      prev_q   <= '0;
      addr_q   <= '0;
      dir_dn_q <= 1'b0;
      req_q    <= 1'b0;
      late_q   <= 1'b0;
      dt_q     <= '0;
      lcnt_q   <= '0;
    end else if (dl_busy) begin
      state_q <= S_DL;
      req_q   <= 1'b0;
      vld_q   <= '0;
      dt_q    <= '0;
      lcnt_q  <= '0;
    end else begin
      if (word != prev_q) begin
        prev_q <= word;
        if (word == prev_q - 17'd1)      dir_dn_q <= 1'b1;
        else if (word == prev_q + 17'd1) dir_dn_q <= 1'b0;
      end
      lcnt_q <= lcnt_d;
      if (lcnt_d == CW'(LATE_CYC)) late_q <= 1'b1;
      if (hit) dt_q <= sprchad[0] ? hword[15:8] : hword[7:0];
      case (state_q)
        S_IDLE: begin
          if (!hit) begin
            addr_q  <= word;
            req_q   <= 1'b1;
            state_q <= S_DEMAND;
          end else if (!nxt_hit) begin
            addr_q  <= nxt;
            req_q   <= 1'b1;
            state_q <= S_PREFETCH;
          end
        end
        S_DEMAND, S_PREFETCH: begin
          if (rom_valid) begin
            vld_q[fill_sel] <= 1'b1;
            tag_q[fill_sel] <= addr_q;
            dat_q[fill_sel] <= rom_data;
            req_q           <= 1'b0;
            state_q         <= S_IDLE;
            // returned word is the one being asked for right now: forward it directly
            if (addr_q == word) dt_q <= sprchad[0] ? rom_data[15:8] : rom_data[7:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sprchdt  = dt_q;
  assign rom_req  = req_q;
  assign rom_addr = addr_q;
  assign late     = late_q;
endmodule

// File: tb/tb_segasys1_sprrom_fetch.sv
// Bench for segasys1_sprrom_fetch: behavioural ROM with programmable latency,
// byte scoreboard and request log.
module tb_segasys1_sprrom_fetch;
  logic        clk = 1'b0;
  logic        RESETn, dl_busy, rom_valid, rom_req, late;
  logic [17:0] sprchad;
  logic [7:0]  sprchdt;
  logic [16:0] rom_addr;
  logic [15:0] rom_data;

  int n_chk = 0, n_err = 0;
  int rom_lat = 5;
  int dropped = 0, unstable = 0;
  logic [7:0]  sbq[$];
  logic [16:0] reqq[$];

  segasys1_sprrom_fetch #(.LATE_CYC(16)) dut (
    .VCLKx8(clk), .RESETn(RESETn), .dl_busy(dl_busy), .sprchad(sprchad),
    .sprchdt(sprchdt), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_valid(rom_valid), .rom_data(rom_data), .late(late)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [16:0] w);
    if (w == 17'h00008) return 16'hBEEF;
    return {w[7:0] ^ 8'h5A, w[7:0] ^ w[15:8] ^ 8'hC3};
  endfunction

  function automatic logic [7:0] rom_byte(input logic [17:0] a);
    logic [15:0] d;
    d = rom_word(a[17:1]);
    return a[0] ? d[15:8] : d[7:0];
  endfunction

  function automatic int nreq(input int from, input logic [16:0] w);
    int n = 0;
    for (int i = from; i < reqq.size(); i++) if (reqq[i] == w) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ROM responder: latches the request, answers rom_lat cycles after rom_req rises
  initial begin
    bit pend = 0;
    int cnt = 0;
    logic [16:0] paddr = '0;
    rom_valid = 1'b0;
    rom_data  = '0;
    forever begin
      @(posedge clk); #1;
      rom_valid = 1'b0;
      if (pend) begin
        if (!rom_req) begin
          pend = 0;
          if (RESETn && !dl_busy) dropped++;
        end else begin
          if (rom_addr != paddr) unstable++;
          if (cnt == 0) begin
            rom_valid = 1'b1;
            rom_data  = rom_word(paddr);
            pend      = 0;
          end else cnt--;
        end
      end else if (rom_req) begin
        paddr = rom_addr;
        reqq.push_back(rom_addr);
        cnt  = rom_lat - 2;
        pend = 1;
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic access(input string tag, input logic [17:0] a, input int bound);
    int cyc = 0;
    bit ok = 0;
    sprchad = a;
    sbq.push_back(rom_byte(a));
    while (cyc < bound && !ok) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (sprchdt === sbq[0]) ok = 1;
    end
    check({tag, "_lat"}, 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_dat"}, 32'(sprchdt), 32'(sbq.pop_front()));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [17:0] a);
    sprchad = a;
    dl_busy = 1'b0;
    RESETn  = 1'b0;
    repeat (3) @(posedge clk);
    #1 RESETn = 1'b1;
  endtask

  initial begin
    int start;
    RESETn = 1'b0; dl_busy = 1'b0; sprchad = 18'h00010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dat", 32'(sprchdt), 0);
    check("rst_req", 32'(rom_req), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_late", 32'(late), 0);
    @(posedge clk); #1 RESETn = 1'b1;

    // cold miss, latency 5
    @(posedge clk); @(negedge clk);
    check("cold_req", 32'(rom_req), 1);
    check("cold_addr", 32'(rom_addr), 32'h00008);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("cold_c5", 32'(sprchdt), 0);
    @(posedge clk); @(negedge clk);
    check("cold_c6", 32'(sprchdt), 32'hEF);
    @(posedge clk); #1 sprchad = 18'h00011;
    @(posedge clk); @(negedge clk);
    check("odd_hit", 32'(sprchdt), 32'hBE);
    check("odd_noreq", 32'(nreq(0, 17'h00008)), 1);

    // demand miss arriving while prefetch of word 9 is in flight
    @(posedge clk); #1;
    access("pf_demand", 18'h20000, 2 * rom_lat + 3);
    check("pf_ord1", 32'(reqq[1]), 32'h00009);
    check("pf_ord2", 32'(reqq[2]), 32'h10000);

    // forward walk, short latency: every byte after the first served within 2 cycles
    rom_lat = 2;
    do_reset(18'h00010);
    start = reqq.size();
    for (int a = 'h10; a <= 'h1F; a++)
      access("fwd", 18'(a), (a == 'h10) ? rom_lat + 2 : 2);
    check("fwd_first", 32'(reqq[start]), 32'h00008);
    check("fwd_pf", 32'(reqq[start + 1]), 32'h00009);

    // h-flipped walk downward
    rom_lat = 5;
    start = reqq.size();
    for (int a = 'h3F; a >= 'h30; a--)
      access("hflip", 18'(a), 2 * rom_lat + 3);
    check("hflip_pf1D", 32'(nreq(start, 17'h0001D) > 0), 1);
    check("hflip_pf1C", 32'(nreq(start, 17'h0001C) > 0), 1);
    check("hflip_pf18", 32'(nreq(start, 17'h00018) > 0), 1);

    // download during a demand miss flushes the cache
    access("pre_dl", 18'h01234, 2 * rom_lat + 3);
    repeat (15) @(posedge clk);
    #1 sprchad = 18'h00200;
    repeat (2) @(posedge clk);
    #1 dl_busy = 1'b1;
    @(posedge clk); @(negedge clk);
    check("dl_req", 32'(rom_req), 0);
    check("dl_dat", 32'(sprchdt), 0);
    repeat (3) @(posedge clk);
    #1 dl_busy = 1'b0;
    access("post_dl", 18'h00200, 2 * rom_lat + 3);
    check("post_dl_req", 32'(nreq(0, 17'h00100)), 2);
    access("refetch", 18'h01234, 2 * rom_lat + 3);
    check("refetch_req", 32'(nreq(0, 17'h0091A)), 2);
    check("late_quiet", 32'(late), 0);

    // slow ROM: late flag at cycle 16, sticky until reset
    rom_lat = 20;
    do_reset(18'h00100);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("late_c15", 32'(late), 0);
    @(posedge clk); @(negedge clk);
    check("late_c16", 32'(late), 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("slow_dat", 32'(sprchdt), 32'(rom_byte(18'h00100)));
    check("late_hold", 32'(late), 1);
    repeat (2) @(posedge clk);
    #1 RESETn = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mid_req", 32'(rom_req), 0);
    check("rst_mid_late", 32'(late), 0);
    check("rst_mid_dat", 32'(sprchdt), 0);
    repeat (2) @(posedge clk);
    #1 RESETn = 1'b1;
    rom_lat = 3;
    access("after_rst", 18'h00101, rom_lat + 2);

    check("no_drop", 32'(dropped), 0);
    check("addr_stable", 32'(unstable), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
